// File: rtl/williams_nv_pkg.sv
// Shared definitions for the Williams CMOS NVRAM upload/download responder.
//   Widths of the hps_io ioctl bus, read FSM state encoding and constants
//   used when packing a CMOS nibble into an upload byte.
package williams_nv_pkg;

  localparam int unsigned IDX_W     = 8;   // ioctl_index width
  localparam int unsigned IOCTL_AW  = 17;  // ioctl_addr width
  localparam int unsigned HOLDOFF_W = 24;  // quiet-time counter width
  localparam int unsigned LAT_W     = 2;   // read latency counter width

  localparam logic [IDX_W-1:0] NV_INDEX_DEF   = 8'd4;
  localparam logic [3:0]       CMOS_HI_NIBBLE = 4'hF;
  localparam logic [7:0]       DIN_IDLE       = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LAT
  } rd_state_t;

endpackage

// File: rtl/williams_nvram_upload.sv
// hps_io ioctl responder for the Williams CMOS (high-score/settings) RAM.
//   Serves HPS upload reads from CMOS port B (nibble packed as {F,nibble}),
//   restores CMOS from a download with the same index, and requests an upload
//   once the game has stopped writing CMOS for HOLDOFF cycles.
// Ports:
//   clk_sys, reset              clock, async active-high reset
//   ioctl_upload/download       HPS transfer in progress
//   ioctl_index, ioctl_addr     transfer index and byte address
//   ioctl_rd / ioctl_wr         1-cycle read (upload) / write (download) strobes
//   ioctl_dout                  download data
//   ioctl_din, ioctl_wait       upload data, stall while a read is in flight
//   ioctl_upload_req            ask HPS to start an NVRAM upload
//   game_cmos_we                game CPU CMOS write strobe (dirty tracking)
//   cmos_addr/dout/din/we       CMOS port B
module williams_nvram_upload
  import williams_nv_pkg::*;
#(
  parameter logic [IDX_W-1:0]     NV_INDEX = NV_INDEX_DEF,
  parameter int unsigned          ADDR_W   = 10,
  parameter int unsigned          RD_LAT   = 1,
  parameter logic [HOLDOFF_W-1:0] HOLDOFF  = 24'd6_000_000
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_upload,
  input  logic                ioctl_download,
  input  logic [IDX_W-1:0]    ioctl_index,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic                ioctl_rd,
  input  logic                ioctl_wr,
  input  logic [7:0]          ioctl_dout,
  output logic [7:0]          ioctl_din,
  output logic                ioctl_wait,
  output logic                ioctl_upload_req,
  input  logic                game_cmos_we,
  output logic [ADDR_W-1:0]   cmos_addr,
  input  logic [3:0]          cmos_dout,
  output logic [3:0]          cmos_din,
  output logic                cmos_we
);

  rd_state_t              rd_state;
  logic [LAT_W-1:0]       lat_cnt;
  logic [HOLDOFF_W-1:0]   holdoff;
  logic                   dirty;
  logic                   sel_up, sel_dn, sel_up_q, sel_dn_q;
  logic                   sel_up_rise, sel_dn_rise;
  logic                   in_range;
  logic                   unused_dout_hi;

  assign sel_up      = ioctl_upload   && (ioctl_index == NV_INDEX);
  assign sel_dn      = ioctl_download && (ioctl_index == NV_INDEX);
  assign sel_up_rise = sel_up && !sel_up_q;
  assign sel_dn_rise = sel_dn && !sel_dn_q;
  assign in_range    = (ioctl_addr >> ADDR_W) == '0;

  // CMOS only stores the low nibble of each download byte
  assign unused_dout_hi = ^ioctl_dout[7:4];

  // Read FSM plus port-B driver; restore writes only happen while the FSM is idle
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_state   <= IDLE;
      lat_cnt    <= '0;
      ioctl_din  <= DIN_IDLE;
      ioctl_wait <= 1'b0;
      cmos_addr  <= '0;
      cmos_din   <= '0;
      cmos_we    <= 1'b0;
    end else begin
      cmos_we <= 1'b0;
      if (ioctl_wr && sel_dn && in_range) begin
        cmos_we   <= 1'b1;
        cmos_addr <= ioctl_addr[ADDR_W-1:0];
        cmos_din  <= ioctl_dout[3:0];
      end

      case (rd_state)
        IDLE: begin
          if (ioctl_rd && sel_up) begin
            if (in_range) begin
              cmos_addr  <= ioctl_addr[ADDR_W-1:0];
              ioctl_wait <= 1'b1;
              rd_state   <= FETCH;
            end else begin
              ioctl_din <= DIN_IDLE;
            end
          end
        end
        FETCH: begin
          if (!sel_up) begin
            ioctl_wait <= 1'b0;
            rd_state   <= IDLE;
          end else begin
            lat_cnt  <= LAT_W'(RD_LAT - 1);
            rd_state <= LAT;
          end
        end
        LAT: begin
          if (!sel_up) begin
            ioctl_wait <= 1'b0;
            rd_state   <= IDLE;
          end else if (lat_cnt == '0) begin
            ioctl_din  <= {CMOS_HI_NIBBLE, cmos_dout};
            ioctl_wait <= 1'b0;
            rd_state   <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

  // Dirty tracking and auto-save request; a game write always wins over clears
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sel_up_q         <= 1'b0;
      sel_dn_q         <= 1'b0;
      dirty            <= 1'b0;
      holdoff          <= '0;
      ioctl_upload_req <= 1'b0;
    end else begin
      sel_up_q <= sel_up;
      sel_dn_q <= sel_dn;

      if (game_cmos_we) begin
        dirty   <= 1'b1;
        holdoff <= HOLDOFF;
      end else if (sel_dn_rise) begin
        dirty   <= 1'b0;
        holdoff <= '0;
      end else begin
        if (sel_up_rise) dirty <= 1'b0;
        if (holdoff != '0) holdoff <= holdoff - 1'b1;
      end

      if (sel_up_rise)
        ioctl_upload_req <= 1'b0;
      else if (dirty && (holdoff == '0) && !ioctl_upload && !ioctl_download)
        ioctl_upload_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_williams_nvram_upload.sv
// Scoreboard bench for williams_nvram_upload: stimulus pushes expected events
// (read completion, CMOS write pulse, upload_req edges) with their cycle stamp;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_williams_nvram_upload;

  typedef enum int {EV_RD, EV_WR, EV_REQ, EV_REQ_FALL} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         cyc;
    logic [7:0] data;
    logic [9:0] addr;
  } ev_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0, ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [16:0] ioctl_addr = 17'd0;
  logic        ioctl_rd = 1'b0, ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait, ioctl_upload_req;
  logic        game_cmos_we = 1'b0;
  logic [9:0]  cmos_addr;
  logic [3:0]  cmos_dout;
  logic [3:0]  cmos_din;
  logic        cmos_we;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t exp_q[$];
  bit  do_reset_chk = 1'b0;
  bit  end_chk = 1'b0;
  bit  wait_prev = 1'b0, rd_prev = 1'b0, req_prev = 1'b0;

  logic [3:0] mem [1024];

  williams_nvram_upload #(
    .NV_INDEX(8'd4), .ADDR_W(10), .RD_LAT(1), .HOLDOFF(24'd100)
  ) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .game_cmos_we(game_cmos_we),
    .cmos_addr(cmos_addr), .cmos_dout(cmos_dout), .cmos_din(cmos_din),
    .cmos_we(cmos_we)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // CMOS port-B model, 1-cycle read latency; contents reload on reset (mem[5]=A)
  always @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'(i);
      mem[5]    <= 4'hA;
      cmos_dout <= 4'h0;
    end else begin
      cmos_dout <= mem[cmos_addr];
      if (cmos_we) mem[cmos_addr] <= cmos_din;
    end
  end

  function automatic ev_t mk_ev(input ev_kind_e k, input int c,
                                input logic [7:0] d, input logic [9:0] a);
    ev_t e;
    e.kind = k; e.cyc = c; e.data = d; e.addr = a;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cyc %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic match_ev(input ev_kind_e k, input logic [7:0] d, input logic [9:0] a);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s: got event at cyc %0d, want no event", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", int'(k), int'(e.kind));
      check({k.name(), "_cyc"}, cyc, e.cyc);
      if (k == e.kind && (k == EV_RD || k == EV_WR)) begin
        check({k.name(), "_data"}, int'(d), int'(e.data));
        check({k.name(), "_addr"}, int'(a), int'(e.addr));
      end
    end
  endtask

  // Monitor: the only process that counts comparisons
  always @(negedge clk_sys) begin
    if (do_reset_chk) begin
      check("rst_din", int'(ioctl_din), 8'hFF);
      check("rst_wait", int'(ioctl_wait), 0);
      check("rst_req", int'(ioctl_upload_req), 0);
      check("rst_cmos_addr", int'(cmos_addr), 0);
      check("rst_cmos_din", int'(cmos_din), 0);
      check("rst_cmos_we", int'(cmos_we), 0);
    end
    if ((wait_prev && !ioctl_wait) || (rd_prev && !wait_prev && !ioctl_wait))
      match_ev(EV_RD, ioctl_din, cmos_addr);
    if (cmos_we === 1'b1)
      match_ev(EV_WR, {4'h0, cmos_din}, cmos_addr);
    if (ioctl_upload_req === 1'b1 && !req_prev)
      match_ev(EV_REQ, 8'h0, 10'h0);
    if (ioctl_upload_req === 1'b0 && req_prev)
      match_ev(EV_REQ_FALL, 8'h0, 10'h0);
    wait_prev = (ioctl_wait === 1'b1);
    rd_prev   = (ioctl_rd === 1'b1);
    req_prev  = (ioctl_upload_req === 1'b1);
    if (end_chk || cyc > 5000) begin
      if (!end_chk) begin
        total++;
        bad++;
        $display("FAIL timeout: got cyc %0d want end before 5000", cyc);
      end
      check("leftover_events", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Upload read strobe; expected completion lat cycles after the drive cycle
  task automatic do_read(input logic [16:0] a, input logic [7:0] exp_din,
                         input logic [9:0] exp_addr, input int lat);
    @(posedge clk_sys); #1;
    exp_q.push_back(mk_ev(EV_RD, cyc + lat, exp_din, exp_addr));
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
  endtask

  task automatic dl_write(input logic [7:0] idx, input logic [16:0] a,
                          input logic [7:0] d, input bit expect_we);
    @(posedge clk_sys); #1;
    if (expect_we) exp_q.push_back(mk_ev(EV_WR, cyc + 1, {4'h0, d[3:0]}, a[9:0]));
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr    = 1'b0;
    ioctl_index = 8'd4;
  endtask

  task automatic game_we(output int c);
    @(posedge clk_sys); #1;
    c = cyc;
    game_cmos_we = 1'b1;
    @(posedge clk_sys); #1;
    game_cmos_we = 1'b0;
  endtask

  task automatic upload_pulse_clear();
    @(posedge clk_sys); #1;
    exp_q.push_back(mk_ev(EV_REQ_FALL, cyc + 1, 8'h0, 10'h0));
    ioctl_upload = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk_sys);
    #1 do_reset_chk = 1'b1;
    @(posedge clk_sys); #1;
    do_reset_chk = 1'b0;
    reset = 1'b0;

    // In-range read of CMOS[5]=A, then a read aborted by upload dropping
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    idle(2);
    do_read(17'd5, 8'hFA, 10'd5, 3);
    idle(2);
    do_read(17'd9, 8'hFA, 10'd9, 2);
    ioctl_upload = 1'b0;
    idle(2);
    ioctl_upload = 1'b1;
    idle(2);
    // Out-of-range read answers FF at once, port-B address untouched
    do_read(17'd1024, 8'hFF, 10'd9, 1);
    idle(3);

    // Restore: one write pulse for index 4, none for index 0 or address 1024
    ioctl_upload   = 1'b0;
    ioctl_download = 1'b1;
    idle(1);
    dl_write(8'd4, 17'd3, 8'h37, 1'b1);
    dl_write(8'd0, 17'd5, 8'h2C, 1'b0);
    dl_write(8'd4, 17'd1024, 8'h1E, 1'b0);
    idle(2);
    ioctl_download = 1'b0;
    ioctl_upload   = 1'b1;
    idle(1);
    do_read(17'd3, 8'hF7, 10'd3, 3);
    idle(2);
    ioctl_upload = 1'b0;
    idle(2);

    // Single game write: req 101 cycles after the sampling edge
    game_we(c);
    exp_q.push_back(mk_ev(EV_REQ, c + 102, 8'h0, 10'h0));
    idle(110);
    // Upload start clears req; simultaneous game write re-arms it
    @(posedge clk_sys); #1;
    c = cyc;
    exp_q.push_back(mk_ev(EV_REQ_FALL, c + 1, 8'h0, 10'h0));
    exp_q.push_back(mk_ev(EV_REQ, c + 102, 8'h0, 10'h0));
    ioctl_upload = 1'b1;
    game_cmos_we = 1'b1;
    @(posedge clk_sys); #1;
    game_cmos_we = 1'b0;
    idle(4);
    ioctl_upload = 1'b0;
    idle(105);
    upload_pulse_clear();
    idle(5);

    // Writes every 50 cycles keep req low until 101 cycles after the last one
    for (int k = 0; k < 4; k++) begin
      game_we(c);
      idle(48);
    end
    exp_q.push_back(mk_ev(EV_REQ, c + 102, 8'h0, 10'h0));
    idle(60);

    // Reset while in LAT drops wait immediately; next read is normal
    @(posedge clk_sys); #1;
    exp_q.push_back(mk_ev(EV_REQ_FALL, cyc + 1, 8'h0, 10'h0));
    ioctl_upload = 1'b1;
    idle(2);
    do_read(17'd9, 8'hFF, 10'd0, 2);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    do_read(17'd7, 8'hF7, 10'd7, 3);
    idle(10);
    end_chk = 1'b1;
    forever @(posedge clk_sys);
  end

endmodule
